// File: rtl/shift_load_controller_pkg.sv
// -----------------------------------------------------------------------------
// shift_load_controller_pkg
// Definitions shared by the shift/load controller and the shift register
// environment:
//   - DEFAULT_WIDTH / DEFAULT_SHIFTS : default word width and shift cycles per word
//   - state_t                        : 2-bit controller state encoding
//                                      (IDLE=0, LOAD=1, SHIFT=2; 3 unused and
//                                      treated as IDLE by the controller)
//   - last_count()                   : terminal value of the 8-bit shift counter
// -----------------------------------------------------------------------------
package shift_load_controller_pkg;

    localparam int DEFAULT_WIDTH  = 4;
    localparam int DEFAULT_SHIFTS = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_SHIFT  = 2'd2,
        ST_UNUSED = 2'd3
    } state_t;

    // Index of the final shift cycle for a given number of shifts per word.
    function automatic logic [7:0] last_count(input int shifts);
        return 8'(shifts - 1);
    endfunction

endpackage : shift_load_controller_pkg

// File: rtl/shift_load_controller_if.sv
// -----------------------------------------------------------------------------
// shift_load_controller_if
// Bundles the producer handshake and the shift register drive/status signals.
//   InData     [WIDTH-1:0]  word offered by the producer
//   InValid                 InData is valid
//   InReady                 controller accepts InData this cycle
//   L                       load strobe to the shift register (1 = load, 0 = shift)
//   D          [WIDTH-1:0]  data to the shift register
//   Busy                    a word is being loaded or shifted
//   Done                    pulse in the final shift cycle of a word
//   ShiftCount [7:0]        index of the current shift cycle
// Modports:
//   master : producer side (drives InData/InValid, observes everything else)
//   slave  : controller side
// -----------------------------------------------------------------------------
interface shift_load_controller_if
    import shift_load_controller_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic [WIDTH-1:0] InData;
    logic             InValid;
    logic             InReady;
    logic             L;
    logic [WIDTH-1:0] D;
    logic             Busy;
    logic             Done;
    logic [7:0]       ShiftCount;

    modport master (
        output InData,
        output InValid,
        input  InReady,
        input  L,
        input  D,
        input  Busy,
        input  Done,
        input  ShiftCount
    );

    modport slave (
        input  InData,
        input  InValid,
        output InReady,
        output L,
        output D,
        output Busy,
        output Done,
        output ShiftCount
    );

endinterface : shift_load_controller_if

// File: rtl/shift_load_controller.sv
// -----------------------------------------------------------------------------
// shift_load_controller
// Upstream feeder for a parallel-load shift register. Each word accepted over
// the valid/ready handshake produces one load cycle (L=1, D=word) followed by
// SHIFTS shift cycles (L=0, D=FILL). A new word can be accepted in the final
// shift cycle so a continuous stream has no idle gap between words.
//
// Ports:
//   C    clock, rising edge
//   R    synchronous active-high reset; wins over a same-cycle handshake
//   bus  slave modport of shift_load_controller_if
//          in : InData, InValid
//          out: InReady (comb), Done (comb),
//               L, D, Busy, ShiftCount (registered)
//
// Parameters:
//   WIDTH   data word width
//   SHIFTS  shift cycles per word after the load cycle, 1..255
//   FILL    value driven on D while idle or shifting
// -----------------------------------------------------------------------------
module shift_load_controller
    import shift_load_controller_pkg::*;
#(
    parameter int               WIDTH  = DEFAULT_WIDTH,
    parameter int               SHIFTS = DEFAULT_SHIFTS,
    parameter logic [WIDTH-1:0] FILL   = {WIDTH{1'b0}}
) (
    input  logic                    C,
    input  logic                    R,
    shift_load_controller_if.slave  bus
);

    localparam logic [7:0] LAST_COUNT = last_count(SHIFTS);

    state_t           state_q;
    state_t           state_d;
    logic             l_q;
    logic             l_d;
    logic [WIDTH-1:0] d_q;
    logic [WIDTH-1:0] d_d;
    logic             busy_q;
    logic             busy_d;
    logic [7:0]       shift_count_q;
    logic [7:0]       shift_count_d;

    logic             last_shift_s;
    logic             in_ready_s;
    logic             accept_s;

    // Handshake decode: ready when idle or in the final shift cycle.
    always_comb begin
        last_shift_s = (state_q == ST_SHIFT) && (shift_count_q == LAST_COUNT);
        // The unused encoding behaves as IDLE, so ready is "not LOAD and not SHIFT".
        in_ready_s   = ((state_q != ST_LOAD) && (state_q != ST_SHIFT)) || last_shift_s;
        accept_s     = bus.InValid && in_ready_s;
    end

    // Next-state and next-output computation; outputs describe the next cycle.
    always_comb begin
        state_d       = ST_IDLE;
        l_d           = 1'b0;
        d_d           = FILL;
        busy_d        = 1'b0;
        shift_count_d = 8'd0;

        case (state_q)
            ST_LOAD: begin
                state_d       = ST_SHIFT;
                busy_d        = 1'b1;
                shift_count_d = 8'd0;
            end

            ST_SHIFT: begin
                if (shift_count_q == LAST_COUNT) begin
                    if (accept_s) begin
                        // Back-to-back: load the next word with no idle gap.
                        state_d = ST_LOAD;
                        l_d     = 1'b1;
                        d_d     = bus.InData;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    // Counter only advances below the terminal value, so it
                    // never runs past SHIFTS-1.
                    state_d       = ST_SHIFT;
                    busy_d        = 1'b1;
                    shift_count_d = shift_count_q + 8'd1;
                end
            end

            default: begin
                // ST_IDLE and the unused encoding.
                if (accept_s) begin
                    state_d = ST_LOAD;
                    l_d     = 1'b1;
                    d_d     = bus.InData;
                    busy_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge C) begin
        if (R) begin
            state_q       <= ST_IDLE;
            l_q           <= 1'b0;
            d_q           <= {WIDTH{1'b0}};
            busy_q        <= 1'b0;
            shift_count_q <= 8'd0;
        end else begin
            state_q       <= state_d;
            l_q           <= l_d;
            d_q           <= d_d;
            busy_q        <= busy_d;
            shift_count_q <= shift_count_d;
        end
    end

    assign bus.InReady    = in_ready_s;
    assign bus.Done       = last_shift_s;
    assign bus.L          = l_q;
    assign bus.D          = d_q;
    assign bus.Busy       = busy_q;
    assign bus.ShiftCount = shift_count_q;

endmodule : shift_load_controller

// File: tb/tb_shift_load_controller.sv
// -----------------------------------------------------------------------------
// tb_shift_load_controller
// Two controller instances: dut0 (SHIFTS=4, FILL=0000) and dut1 (SHIFTS=1,
// FILL=1111). A reference model tracks, per instance, the cycle span occupied
// by the current word (load cycle at 'start', shift cycles start+1..start+S)
// and derives all expected outputs from cycle arithmetic.
// -----------------------------------------------------------------------------
module tb_shift_load_controller;

    logic C = 1'b0;
    logic R;

    always #5 C = ~C;

    shift_load_controller_if #(.WIDTH(4)) bus0();
    shift_load_controller_if #(.WIDTH(4)) bus1();

    shift_load_controller #(.WIDTH(4), .SHIFTS(4), .FILL(4'h0)) dut0 (
        .C   (C),
        .R   (R),
        .bus (bus0)
    );

    shift_load_controller #(.WIDTH(4), .SHIFTS(1), .FILL(4'hF)) dut1 (
        .C   (C),
        .R   (R),
        .bus (bus1)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model state per instance
    int         m_s      [2];
    logic [3:0] m_fill   [2];
    bit         m_active [2];
    int         m_start  [2];
    int         m_end    [2];
    logic [3:0] m_word   [2];
    bit         m_dzero  [2];
    bit         m_acc    [2];

    // Apply one rising edge to the model; cyc is the period that now begins.
    function automatic void model_update(int id, logic r, logic v, logic [3:0] d);
        bit rdy;
        m_acc[id] = 1'b0;
        if (r) begin
            m_active[id] = 1'b0;
            m_dzero[id]  = 1'b1;
        end else begin
            rdy = !m_active[id] || ((cyc - 1) == m_end[id]);
            if (v && rdy) begin
                m_active[id] = 1'b1;
                m_start[id]  = cyc;
                m_end[id]    = cyc + m_s[id];
                m_word[id]   = d;
                m_acc[id]    = 1'b1;
            end else if (m_active[id] && (cyc > m_end[id])) begin
                m_active[id] = 1'b0;
            end
            m_dzero[id] = 1'b0;
        end
    endfunction

    // Expected {InReady, L, D, Busy, Done, ShiftCount} for the current period.
    function automatic logic [15:0] exp_vec(int id);
        logic       rdy;
        logic       l;
        logic [3:0] d;
        logic       busy;
        logic       done;
        logic [7:0] cnt;
        rdy  = 1'b1;
        l    = 1'b0;
        d    = m_dzero[id] ? 4'h0 : m_fill[id];
        busy = 1'b0;
        done = 1'b0;
        cnt  = 8'd0;
        if (m_active[id] && (cyc == m_start[id])) begin
            rdy  = 1'b0;
            l    = 1'b1;
            d    = m_word[id];
            busy = 1'b1;
        end else if (m_active[id] && (cyc > m_start[id]) && (cyc <= m_end[id])) begin
            d    = m_fill[id];
            busy = 1'b1;
            cnt  = 8'(cyc - m_start[id] - 1);
            done = (cyc == m_end[id]);
            rdy  = done;
        end
        return {rdy, l, d, busy, done, cnt};
    endfunction

    function automatic logic [15:0] obs_vec(int id);
        if (id == 0)
            return {bus0.InReady, bus0.L, bus0.D, bus0.Busy, bus0.Done, bus0.ShiftCount};
        else
            return {bus1.InReady, bus1.L, bus1.D, bus1.Busy, bus1.Done, bus1.ShiftCount};
    endfunction

    task automatic tick();
        @(posedge C);
        cyc++;
        model_update(0, R, bus0.InValid, bus0.InData);
        model_update(1, R, bus1.InValid, bus1.InData);
        #1;
    endtask

    task automatic test_reset();
        R = 1'b1;
        bus0.InValid = 1'b1; bus0.InData = 4'b1111;
        bus1.InValid = 1'b1; bus1.InData = 4'b1111;
        for (int k = 0; k < 2; k++) begin
            tick();
            for (int id = 0; id < 2; id++) begin
                n_checks++;
                if (obs_vec(id) !== exp_vec(id)) begin
                    n_fail++;
                    $display("FAIL reset_vec dut%0d cyc=%0d got=%h want=%h", id, cyc, obs_vec(id), exp_vec(id));
                end
            end
        end
        n_checks++;
        if ({bus0.L, bus0.D, bus0.Busy, bus0.InReady, bus0.Done} !== 8'b0_0000_0_1_0) begin
            n_fail++;
            $display("FAIL reset_outputs got L=%b D=%b Busy=%b InReady=%b Done=%b want 0 0000 0 1 0",
                     bus0.L, bus0.D, bus0.Busy, bus0.InReady, bus0.Done);
        end
        R = 1'b0;
        bus0.InValid = 1'b0;
        bus1.InValid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            for (int id = 0; id < 2; id++) begin
                n_checks++;
                if (obs_vec(id) !== exp_vec(id)) begin
                    n_fail++;
                    $display("FAIL reset_release dut%0d cyc=%0d got=%h want=%h", id, cyc, obs_vec(id), exp_vec(id));
                end
            end
        end
    endtask

    task automatic test_single_word();
        int done_n = 0;
        bus0.InValid = 1'b1; bus0.InData = 4'b1011;
        for (int k = 0; k < 8; k++) begin
            tick();
            bus0.InValid = 1'b0;
            n_checks++;
            if (obs_vec(0) !== exp_vec(0)) begin
                n_fail++;
                $display("FAIL single_vec off=%0d got=%h want=%h", k, obs_vec(0), exp_vec(0));
            end
            if (bus0.Done === 1'b1) done_n++;
            if (k == 0) begin
                n_checks++;
                if (!(bus0.L === 1'b1 && bus0.D === 4'b1011)) begin
                    n_fail++;
                    $display("FAIL single_load got L=%b D=%b want L=1 D=1011", bus0.L, bus0.D);
                end
            end
            if (k == 5) begin
                n_checks++;
                if (bus0.Busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL single_idle got Busy=%b want 0", bus0.Busy);
                end
            end
        end
        n_checks++;
        if (done_n != 1) begin
            n_fail++;
            $display("FAIL single_done_count got %0d want 1", done_n);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] words [4];
        int         l_cyc [4];
        logic [3:0] l_dat [4];
        int idx = 0;
        int l_n = 0;
        int done_n = 0;
        words[0] = 4'b1111; words[1] = 4'b1110; words[2] = 4'b1110; words[3] = 4'b1111;
        bus0.InValid = 1'b1; bus0.InData = words[0];
        for (int k = 0; k < 30; k++) begin
            tick();
            if (m_acc[0]) begin
                idx++;
                if (idx < 4) bus0.InData = words[idx];
                else bus0.InValid = 1'b0;
            end
            n_checks++;
            if (obs_vec(0) !== exp_vec(0)) begin
                n_fail++;
                $display("FAIL b2b_vec cyc=%0d got=%h want=%h", cyc, obs_vec(0), exp_vec(0));
            end
            if (bus0.L === 1'b1 && l_n < 4) begin
                l_cyc[l_n] = cyc;
                l_dat[l_n] = bus0.D;
                l_n++;
            end
            if (bus0.Done === 1'b1) done_n++;
        end
        n_checks++;
        if (l_n != 4 || done_n != 4) begin
            n_fail++;
            $display("FAIL b2b_counts got loads=%0d dones=%0d want 4 4", l_n, done_n);
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (l_dat[i] !== words[i] || (i > 0 && (l_cyc[i] - l_cyc[i-1]) != 5)) begin
                    n_fail++;
                    $display("FAIL b2b_word%0d got D=%b gap=%0d want D=%b gap=5", i, l_dat[i],
                             (i > 0) ? (l_cyc[i] - l_cyc[i-1]) : 5, words[i]);
                end
            end
        end
    endtask

    task automatic test_stall();
        bus0.InValid = 1'b1; bus0.InData = 4'b1011;
        for (int k = 0; k <= 12; k++) begin
            tick();
            if (k == 0 || m_acc[0]) bus0.InValid = 1'b0;
            if (k == 1) begin
                bus0.InValid = 1'b1;
                bus0.InData  = 4'b0110;
            end
            n_checks++;
            if (obs_vec(0) !== exp_vec(0)) begin
                n_fail++;
                $display("FAIL stall_vec off=%0d got=%h want=%h", k, obs_vec(0), exp_vec(0));
            end
            if (k >= 1 && k <= 4) begin
                n_checks++;
                if (bus0.InReady !== (k == 4)) begin
                    n_fail++;
                    $display("FAIL stall_ready off=%0d got %b want %b", k, bus0.InReady, (k == 4));
                end
            end
            if (k == 5) begin
                n_checks++;
                if (!(bus0.L === 1'b1 && bus0.D === 4'b0110)) begin
                    n_fail++;
                    $display("FAIL stall_load got L=%b D=%b want L=1 D=0110", bus0.L, bus0.D);
                end
            end
        end
    endtask

    task automatic test_abort();
        int done_n = 0;
        bus0.InValid = 1'b1; bus0.InData = 4'b1011;
        for (int k = 0; k < 10; k++) begin
            tick();
            bus0.InValid = 1'b0;
            R = 1'b0;
            if (k == 2) R = 1'b1;
            n_checks++;
            if (obs_vec(0) !== exp_vec(0)) begin
                n_fail++;
                $display("FAIL abort_vec off=%0d got=%h want=%h", k, obs_vec(0), exp_vec(0));
            end
            if (bus0.Done === 1'b1) done_n++;
            if (k == 3) begin
                n_checks++;
                if ({bus0.L, bus0.Busy, bus0.InReady} !== 3'b001) begin
                    n_fail++;
                    $display("FAIL abort_idle got L=%b Busy=%b InReady=%b want 0 0 1", bus0.L, bus0.Busy, bus0.InReady);
                end
            end
        end
        n_checks++;
        if (done_n != 0) begin
            n_fail++;
            $display("FAIL abort_done got %0d pulses want 0", done_n);
        end
    endtask

    task automatic test_boundary();
        logic [3:0] words [2];
        logic       exp_l [4];
        logic [3:0] exp_d [4];
        int idx = 0;
        words[0] = 4'b0001; words[1] = 4'b0010;
        exp_l[0] = 1'b1; exp_l[1] = 1'b0; exp_l[2] = 1'b1; exp_l[3] = 1'b0;
        exp_d[0] = 4'b0001; exp_d[1] = 4'b1111; exp_d[2] = 4'b0010; exp_d[3] = 4'b1111;
        bus1.InValid = 1'b1; bus1.InData = words[0];
        for (int k = 0; k < 6; k++) begin
            tick();
            if (m_acc[1]) begin
                idx++;
                if (idx < 2) bus1.InData = words[idx];
                else bus1.InValid = 1'b0;
            end
            n_checks++;
            if (obs_vec(1) !== exp_vec(1)) begin
                n_fail++;
                $display("FAIL bound_vec off=%0d got=%h want=%h", k, obs_vec(1), exp_vec(1));
            end
            if (k < 4) begin
                n_checks++;
                if (bus1.L !== exp_l[k] || bus1.D !== exp_d[k] ||
                    (exp_l[k] == 1'b0 && {bus1.Done, bus1.InReady} !== 2'b11)) begin
                    n_fail++;
                    $display("FAIL bound_seq off=%0d got L=%b D=%b Done=%b InReady=%b want L=%b D=%b",
                             k, bus1.L, bus1.D, bus1.Done, bus1.InReady, exp_l[k], exp_d[k]);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 500; k++) begin
            R = ($urandom_range(0, 49) == 0);
            // Producer only changes its offer when none is pending.
            if (!bus0.InValid || m_acc[0]) begin
                bus0.InValid = 1'($urandom_range(0, 1));
                bus0.InData  = 4'($urandom);
            end
            if (!bus1.InValid || m_acc[1]) begin
                bus1.InValid = 1'($urandom_range(0, 1));
                bus1.InData  = 4'($urandom);
            end
            tick();
            for (int id = 0; id < 2; id++) begin
                n_checks++;
                if (obs_vec(id) !== exp_vec(id)) begin
                    n_fail++;
                    $display("FAIL random_vec dut%0d cyc=%0d got=%h want=%h", id, cyc, obs_vec(id), exp_vec(id));
                end
            end
        end
        R = 1'b0;
        bus0.InValid = 1'b0;
        bus1.InValid = 1'b0;
    endtask

    initial begin
        m_s[0] = 4; m_fill[0] = 4'h0;
        m_s[1] = 1; m_fill[1] = 4'hF;
        for (int id = 0; id < 2; id++) begin
            m_active[id] = 1'b0;
            m_start[id]  = 0;
            m_end[id]    = 0;
            m_word[id]   = 4'h0;
            m_dzero[id]  = 1'b1;
            m_acc[id]    = 1'b0;
        end
        R = 1'b1;
        bus0.InValid = 1'b0; bus0.InData = 4'h0;
        bus1.InValid = 1'b0; bus1.InData = 4'h0;

        test_reset();
        test_single_word();
        test_back_to_back();
        test_stall();
        test_abort();
        test_boundary();
        test_random();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout cyc=%0d limit reached", cyc);
        $fatal(1, "timeout");
    end

endmodule : tb_shift_load_controller
